// File: rtl/modulo_varredura_16.sv
// Round-robin scan controller for the 1:16 demux return line: dwells on each
// channel, debounces hits per channel and reports new activations over valid/ack.
module modulo_varredura_16 #(
    parameter int DWELL    = 4,
    parameter int DEBOUNCE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       scan_in,
    input  logic       evt_ack,
    output logic [3:0] dmx16_sel,
    output logic       evt_valid,
    output logic [3:0] evt_sel,
    output logic       evt_lost
);

    localparam int DW_W = $clog2(DWELL);
    localparam int DB_W = $clog2(DEBOUNCE + 1);

    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [DB_W-1:0] DB_MAX     = DB_W'(DEBOUNCE);
    localparam logic [DB_W-1:0] DB_ARM     = DB_W'(DEBOUNCE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [DW_W-1:0] dwell_q;
    logic [DB_W-1:0] db_q [16];
    logic            sample;
    logic            fire;

    function automatic logic [DB_W-1:0] sat_inc(input logic [DB_W-1:0] v);
        return (v < DB_MAX) ? v + 1'b1 : DB_MAX;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en)  state_d = SCAN;
            SCAN:    if (!en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // An edge with en low abandons the slot, so it never samples.
    assign sample = (state_q == SCAN) && en && (dwell_q == DWELL_LAST);
    assign fire   = sample && scan_in && (db_q[dmx16_sel] == DB_ARM);

    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_q   <= '0;
            dmx16_sel <= 4'd0;
        end else if (state_q == SCAN && en) begin
            if (dwell_q == DWELL_LAST) begin
                dwell_q   <= '0;
                dmx16_sel <= dmx16_sel + 4'd1;
            end else begin
                dwell_q <= dwell_q + 1'b1;
            end
        end else begin
            dwell_q <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state_q == IDLE) begin
            for (int i = 0; i < 16; i++) db_q[i] <= '0;
        end else if (sample) begin
            if (scan_in) db_q[dmx16_sel] <= sat_inc(db_q[dmx16_sel]);
            else         db_q[dmx16_sel] <= '0;
        end
    end

    // A fire on the same edge as an ack replaces the acknowledged event.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid <= 1'b0;
            evt_sel   <= 4'd0;
            evt_lost  <= 1'b0;
        end else if (fire) begin
            if (!evt_valid || evt_ack) begin
                evt_valid <= 1'b1;
                evt_sel   <= dmx16_sel;
            end else begin
                evt_lost <= 1'b1;
            end
        end else if (evt_ack) begin
            evt_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_modulo_varredura_16.sv
// Randomized scoreboard bench for modulo_varredura_16: a channel/frame level
// reference model predicts every cycle's outputs, a monitor compares them.
module tb_modulo_varredura_16;

    localparam int DWELL    = 4;
    localparam int DEBOUNCE = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       scan_in = 1'b0;
    logic       evt_ack = 1'b0;
    logic [3:0] dmx16_sel;
    logic       evt_valid;
    logic [3:0] evt_sel;
    logic       evt_lost;

    modulo_varredura_16 #(.DWELL(DWELL), .DEBOUNCE(DEBOUNCE)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .scan_in   (scan_in),
        .evt_ack   (evt_ack),
        .dmx16_sel (dmx16_sel),
        .evt_valid (evt_valid),
        .evt_sel   (evt_sel),
        .evt_lost  (evt_lost)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] sel;
        logic       v;
        logic [3:0] es;
        logic       lost;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    // Reference model state: scanning flag, cycles spent on current channel,
    // current channel, consecutive high frames per channel, event register.
    bit   m_scan;
    int   m_age;
    int   m_ch;
    int   m_hits[16];
    bit   m_pend;
    int   m_psel;
    bit   m_lost;

    bit   press[16];
    int   en_off = 0;

    task automatic model_step(input bit r, input bit e, input bit s, input bit a);
        bit   fire;
        int   fch;
        exp_t x;
        fire = 0;
        fch  = 0;
        if (r) begin
            m_scan = 0; m_age = 0; m_ch = 0;
            for (int i = 0; i < 16; i++) m_hits[i] = 0;
            m_pend = 0; m_psel = 0; m_lost = 0;
        end else begin
            if (!m_scan) begin
                if (e) m_scan = 1;
            end else if (!e) begin
                m_scan = 0;
                m_age  = 0;
                for (int i = 0; i < 16; i++) m_hits[i] = 0;
            end else if (m_age == DWELL - 1) begin
                if (s) begin
                    if (m_hits[m_ch] + 1 == DEBOUNCE) begin
                        fire = 1;
                        fch  = m_ch;
                    end
                    if (m_hits[m_ch] < DEBOUNCE) m_hits[m_ch]++;
                end else begin
                    m_hits[m_ch] = 0;
                end
                m_ch  = (m_ch + 1) % 16;
                m_age = 0;
            end else begin
                m_age++;
            end
            if (fire) begin
                if (!m_pend || a) begin
                    m_pend = 1;
                    m_psel = fch;
                end else begin
                    m_lost = 1;
                end
            end else if (a) begin
                m_pend = 0;
            end
        end
        x.sel  = 4'(m_ch);
        x.v    = m_pend;
        x.es   = 4'(m_psel);
        x.lost = m_lost;
        exp_q.push_back(x);
    endtask

    // Drive one cycle; scan_in is noise except on the edge that samples.
    task automatic drive_cycle(input bit r, input bit e, input bit a);
        bit s;
        @(negedge clk);
        if (!r && m_scan && e && m_age == DWELL - 1) s = press[m_ch];
        else                                          s = 1'($urandom);
        rst     = r;
        en      = e;
        evt_ack = a;
        scan_in = s;
        model_step(r, e, s, a);
    endtask

    task automatic run_frames(input int nframes, input int ack_pct,
                              input int drop_pm, input int rst_pm);
        bit r;
        bit e;
        bit a;
        for (int c = 0; c < nframes * 16 * DWELL; c++) begin
            r = ($urandom_range(999) < rst_pm);
            if (en_off > 0) begin
                en_off--;
                e = 0;
            end else if ($urandom_range(999) < drop_pm) begin
                en_off = $urandom_range(5);
                e = 0;
            end else begin
                e = 1;
            end
            a = ($urandom_range(99) < ack_pct);
            drive_cycle(r, e, a);
        end
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                vectors++;
                if (dmx16_sel !== x.sel || evt_valid !== x.v ||
                    evt_sel !== x.es || evt_lost !== x.lost) begin
                    miscompares++;
                    $display("FAIL outputs cycle %0d: got sel=%0d valid=%0b evt_sel=%0d lost=%0b, want sel=%0d valid=%0b evt_sel=%0d lost=%0b",
                             cyc, dmx16_sel, evt_valid, evt_sel, evt_lost,
                             x.sel, x.v, x.es, x.lost);
                end
            end
        end
    end

    initial begin : stimulus
        int guard;
        for (int i = 0; i < 16; i++) press[i] = 0;
        repeat (2) drive_cycle(1, 0, 0);
        // idle scan, then debounce on 5, then drop of 9 while 5 pending
        run_frames(2, 0, 0, 0);
        press[5] = 1;
        run_frames(3, 0, 0, 0);
        press[9] = 1;
        press[5] = 0;
        run_frames(1, 0, 0, 0);
        press[9] = 0;
        run_frames(1, 0, 0, 0);
        press[9] = 1;
        run_frames(3, 0, 0, 0);
        run_frames(2, 30, 0, 0);
        for (int p = 0; p < 40; p++) begin
            for (int i = 0; i < 16; i++) press[i] = ($urandom_range(3) == 0);
            run_frames($urandom_range(1, 3), $urandom_range(40),
                       $urandom_range(8), $urandom_range(2));
        end
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
